// File: rtl/debounce_bank.sv
// Multi-channel push-button debouncer: 2-FF synchroniser, tick prescaler, stability window, press/release pulses.
// Optional auto-repeat on held buttons is compiled in when DEBOUNCE_AUTOREPEAT_EN is defined.
module debounce_bank #(
    parameter int CHANNELS     = 4,
    parameter int TICK_DIV     = 500000,
    parameter int STABLE_TICKS = 3,
    parameter int ACTIVE_LOW   = 1,
    parameter int REPEAT_DELAY = 100,
    parameter int REPEAT_RATE  = 20
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] btn_in,
    output logic [CHANNELS-1:0] btn_level,
    output logic [CHANNELS-1:0] btn_press,
    output logic [CHANNELS-1:0] btn_release,
    output logic                sample_tick
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CW = $clog2(STABLE_TICKS + 1);
    localparam logic [PW-1:0]       DIV_LAST = PW'(TICK_DIV - 1);
    localparam logic [CW-1:0]       CNT_LAST = CW'(STABLE_TICKS - 1);
    localparam logic [CHANNELS-1:0] INACTIVE = (ACTIVE_LOW != 0) ? '1 : '0;

    logic [CHANNELS-1:0]         sync1_q, sync1_d;
    logic [CHANNELS-1:0]         sync2_q, sync2_d;
    logic [PW-1:0]               div_q, div_d;
    logic                        tick_q, tick_d;
    logic [CHANNELS-1:0]         level_q, level_d;
    logic [CHANNELS-1:0]         press_q, press_d;
    logic [CHANNELS-1:0]         release_q, release_d;
    logic [CHANNELS-1:0][CW-1:0] cnt_q, cnt_d;
    logic [CHANNELS-1:0]         act;

`ifdef DEBOUNCE_AUTOREPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW   = $clog2(RMAX + 1);
    // Counts down ticks to the next repeat pulse; zero whenever the level is released.
    logic [CHANNELS-1:0][RW-1:0] rpt_q, rpt_d;
`endif

    always_comb begin
        sync1_d   = btn_in;
        sync2_d   = sync1_q;
        div_d     = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
        tick_d    = (div_d == DIV_LAST);
        act       = (ACTIVE_LOW != 0) ? ~sync2_q : sync2_q;
        level_d   = level_q;
        press_d   = '0;
        release_d = '0;
        cnt_d     = cnt_q;
        if (tick_q) begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (act[i] == level_q[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] == CNT_LAST) begin
                    level_d[i]   = act[i];
                    cnt_d[i]     = '0;
                    press_d[i]   = act[i];
                    release_d[i] = ~act[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
`ifdef DEBOUNCE_AUTOREPEAT_EN
        rpt_d = rpt_q;
        if (tick_q) begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (press_d[i]) begin
                    rpt_d[i] = RW'(REPEAT_DELAY);
                end else if (!level_d[i]) begin
                    rpt_d[i] = '0;
                end else if (rpt_q[i] == RW'(1)) begin
                    press_d[i] = 1'b1;
                    rpt_d[i]   = RW'(REPEAT_RATE);
                end else begin
                    rpt_d[i] = rpt_q[i] - 1'b1;
                end
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= INACTIVE;
            sync2_q   <= INACTIVE;
            div_q     <= '0;
            tick_q    <= 1'b0;
            level_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
            cnt_q     <= '0;
`ifdef DEBOUNCE_AUTOREPEAT_EN
            rpt_q     <= '0;
`endif
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            div_q     <= div_d;
            tick_q    <= tick_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            cnt_q     <= cnt_d;
`ifdef DEBOUNCE_AUTOREPEAT_EN
            rpt_q     <= rpt_d;
`endif
        end
    end

    assign btn_level   = level_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;
    assign sample_tick = tick_q;

endmodule

// File: tb/tb_debounce_bank.sv
// Bench for debounce_bank: sample-history reference model feeding an event scoreboard,
// directed scenarios followed by randomized bouncing pads.
module tb_debounce_bank;
    localparam int CH = 4;
    localparam int TD = 4;
    localparam int ST = 3;
    localparam int AL = 1;
    localparam int RD = 5;
    localparam int RR = 2;
    localparam int W  = 32 + 2 * CH;
    localparam logic [CH-1:0] INACT = (AL != 0) ? '1 : '0;
    localparam logic [ST-1:0] ONES  = '1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [CH-1:0] btn_in = '1;
    logic [CH-1:0] btn_level, btn_press, btn_release;
    logic          sample_tick;

    always #5 clk = ~clk;

    debounce_bank #(
        .CHANNELS(CH), .TICK_DIV(TD), .STABLE_TICKS(ST), .ACTIVE_LOW(AL),
        .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
    ) dut (
        .clk(clk), .rst_n(rst_n), .btn_in(btn_in), .btn_level(btn_level),
        .btn_press(btn_press), .btn_release(btn_release), .sample_tick(sample_tick)
    );

    int checks = 0;
    int fails  = 0;
    logic [W-1:0] exp_q[$];
    logic [31:0]  cyc = 0;
    logic         mon_en = 1'b0;

    // Reference model: pad history delayed two clocks, last ST samples per channel.
    int            n;
    logic [CH-1:0] pad_q[$];
    logic [ST-1:0] hist[CH];
    int            held[CH];
    logic [CH-1:0] m_level;
    logic          m_tick;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, got, exp);
        end
    endtask

    task model_reset;
        n = 0;
        pad_q.delete();
        pad_q.push_back(INACT);
        pad_q.push_back(INACT);
        for (int c = 0; c < CH; c++) begin
            hist[c] = '0;
            held[c] = 0;
        end
        m_level = '0;
        m_tick  = 1'b0;
        exp_q.delete();
    endtask

    task model_step;
        logic [CH-1:0] samp, a, pr, rl;
        n++;
        samp = pad_q.pop_front();
        pad_q.push_back(btn_in);
        a  = (AL != 0) ? ~samp : samp;
        pr = '0;
        rl = '0;
        if (n % TD == 0) begin
            for (int c = 0; c < CH; c++) begin
                hist[c] = (hist[c] << 1) | ST'(a[c]);
                if (hist[c] == (m_level[c] ? ST'(0) : ONES)) begin
                    m_level[c] = a[c];
                    if (a[c]) begin
                        pr[c]   = 1'b1;
                        held[c] = 0;
                    end else begin
                        rl[c] = 1'b1;
                    end
                end else if (m_level[c]) begin
`ifdef DEBOUNCE_AUTOREPEAT_EN
                    held[c]++;
                    if (held[c] == RD || (held[c] > RD && (held[c] - RD) % RR == 0)) pr[c] = 1'b1;
`endif
                end
            end
        end
        m_tick = (n % TD == TD - 1);
        if ((pr | rl) != '0) exp_q.push_back({cyc + 32'd1, pr, rl});
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else model_step();
    end

    // Monitor: levels and tick every cycle, pulses against the scoreboard queue.
    always @(negedge clk) begin
        if (mon_en) begin
            logic          has;
            logic [W-1:0]  e;
            chk("level", 32'(btn_level), 32'(m_level));
            chk("sample_tick", 32'(sample_tick), 32'(m_tick));
            has = (exp_q.size() > 0) && (exp_q[0][W-1:2*CH] == cyc);
            if (has || btn_press != '0 || btn_release != '0) begin
                e = has ? exp_q.pop_front() : {cyc, {(2*CH){1'b0}}};
                chk("pulses", 32'({btn_press, btn_release}), 32'(e[2*CH-1:0]));
            end
        end
    end

    task automatic wait_clocks(input int k);
        repeat (k) @(negedge clk);
    endtask

    initial begin
        int k;
        int hold_left[CH];
        #1 rst_n = 1'b0;
        mon_en = 1'b1;
        wait_clocks(3);
        chk("rst_level", 32'(btn_level), 0);
        chk("rst_press", 32'(btn_press), 0);
        chk("rst_release", 32'(btn_release), 0);
        chk("rst_tick", 32'(sample_tick), 0);
        rst_n = 1'b1;

        // Idle pads: no activity, tick every TD clocks.
        wait_clocks(100);

        // Clean press and release on channel 0 with latency window.
        btn_in[0] = 1'b0;
        k = 0;
        while (!btn_level[0] && k < 30) begin
            @(negedge clk);
            k++;
        end
        chk("press_latency_ok", 32'(k >= 11 && k <= 14), 1);
        wait_clocks(10 * TD);
        btn_in[0] = 1'b1;
        k = 0;
        while (btn_level[0] && k < 30) begin
            @(negedge clk);
            k++;
        end
        chk("release_latency_ok", 32'(k >= 11 && k <= 14), 1);
        wait_clocks(5 * TD);

        // Bounce on channel 1 shorter than the window.
        btn_in[1] = 1'b0; wait_clocks(2 * TD);
        btn_in[1] = 1'b1; wait_clocks(TD);
        btn_in[1] = 1'b0; wait_clocks(2 * TD);
        btn_in[1] = 1'b1; wait_clocks(5 * TD);
        chk("bounce_level1", 32'(btn_level[1]), 0);

        // Simultaneous press on channels 2 and 3.
        btn_in[3:2] = 2'b00;
        k = 0;
        while (!btn_press[2] && k < 30) begin
            @(negedge clk);
            k++;
        end
        chk("simul_press", 32'(btn_press[3:2]), 32'h3);
        wait_clocks(4 * TD);
        btn_in = '1;
        wait_clocks(6 * TD);

        // Reset in the middle of a release window.
        btn_in[0] = 1'b0;
        wait_clocks(6 * TD);
        btn_in[0] = 1'b1;
        wait_clocks(10);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_level", 32'(btn_level), 0);
        chk("midrst_press", 32'(btn_press), 0);
        chk("midrst_release", 32'(btn_release), 0);
        chk("midrst_tick", 32'(sample_tick), 0);
        @(negedge clk);
        btn_in = '1;
        rst_n  = 1'b1;
        wait_clocks(10 * TD);

`ifdef DEBOUNCE_AUTOREPEAT_EN
        // Held press with auto-repeat, then release.
        btn_in[0] = 1'b0;
        wait_clocks(16 * TD);
        btn_in[0] = 1'b1;
        wait_clocks(8 * TD);
`endif

        // Randomized bouncing pads on all channels.
        for (int c = 0; c < CH; c++) hold_left[c] = 0;
        repeat (3000) begin
            @(negedge clk);
            for (int c = 0; c < CH; c++) begin
                if (hold_left[c] == 0) begin
                    btn_in[c]    = 1'($urandom_range(0, 1));
                    hold_left[c] = $urandom_range(0, 7) == 0 ? $urandom_range(20, 80) : $urandom_range(1, 14);
                end else begin
                    hold_left[c]--;
                end
            end
        end
        btn_in = '1;
        wait_clocks(10 * TD);
        chk("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
